// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared FSM state encoding, opcode constants and result width for alu_seq.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    localparam int RES_W = 128;

endpackage

// File: rtl/alu_seq.sv
// alu_seq: one-at-a-time request sequencer in front of the 64-bit alu pipeline,
// with a single-cycle opcode pulse and a watchdog that turns a lost completion into an error.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [63:0]      alu_A,
    output logic [63:0]      alu_B,
    output logic [1:0]       alu_opCode,
    input  logic [RES_W-1:0] alu_C,
    input  logic             alu_completed,
    output logic             busy,
    output logic [31:0]      op_count
);

    state_t             state_q;
    logic [7:0]         wdog_q;
    logic [RES_W-1:0]   data_q;
    logic [TAG_W-1:0]   tag_q;
    logic               err_q;
    logic [63:0]        a_q;
    logic [63:0]        b_q;
    logic [1:0]         opcode_q;
    logic [31:0]        count_q;

    // req_ready is held low while reset is asserted, even though the state reads IDLE
    assign req_ready  = resetn && state_q == S_IDLE;
    assign rsp_valid  = state_q == S_HOLD;
    assign busy       = state_q != S_IDLE;
    assign rsp_data   = data_q;
    assign rsp_tag    = tag_q;
    assign rsp_err    = err_q;
    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_opCode = opcode_q;
    assign op_count   = count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            wdog_q   <= '0;
            data_q   <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            opcode_q <= OP_NOP;
            count_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    a_q   <= req_a;
                    b_q   <= req_b;
                    tag_q <= req_tag;
                    if (req_op == OP_NOP) begin
                        data_q  <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_HOLD;
                    end else begin
                        opcode_q <= req_op;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    opcode_q <= OP_NOP;
                    wdog_q   <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    wdog_q <= wdog_q + 8'd1;
                    // completion takes priority over an expiring watchdog
                    if (alu_completed) begin
                        data_q  <= alu_C;
                        err_q   <= 1'b0;
                        state_q <= S_HOLD;
                    end else if (wdog_q == 8'(TIMEOUT - 1)) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: if (rsp_ready) begin
                    state_q <= S_IDLE;
                    if (!err_q) count_q <= count_q + 32'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: drives alu_seq against a behavioural alu stub and checks responses
// against expected results computed directly from the operands.
module tb_alu_seq;

    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [63:0]  req_a = '0;
    logic [63:0]  req_b = '0;
    logic [1:0]   req_op = '0;
    logic [3:0]   req_tag = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_data;
    logic [3:0]   rsp_tag;
    logic         rsp_err;
    logic [63:0]  alu_A;
    logic [63:0]  alu_B;
    logic [1:0]   alu_opCode;
    logic [127:0] alu_C;
    logic         alu_completed;
    logic         busy;
    logic [31:0]  op_count;

    logic drop = 1'b0;
    logic inject = 1'b0;
    int   n_pass = 0;
    int   n_tot = 0;
    int   exp_count = 0;
    int   pulse_cnt = 0;

    always #5 clk = ~clk;

    alu_seq #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .alu_A(alu_A), .alu_B(alu_B), .alu_opCode(alu_opCode),
        .alu_C(alu_C), .alu_completed(alu_completed),
        .busy(busy), .op_count(op_count)
    );

    // alu stub: operands registered on the edge that sees the opcode, result one edge later
    logic [1:0]          s1_op;
    logic signed [127:0] s1_a, s1_b;
    logic                comp_q;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_op <= '0; s1_a <= '0; s1_b <= '0; alu_C <= '0; comp_q <= 1'b0;
        end else begin
            s1_op  <= alu_opCode;
            s1_a   <= $signed(alu_A);
            s1_b   <= $signed(alu_B);
            alu_C  <= s1_op == 2'd1 ? s1_a + s1_b : s1_op == 2'd2 ? s1_a * s1_b : 128'd0;
            comp_q <= s1_op != 2'd0 && !drop;
        end
    end
    assign alu_completed = comp_q | inject;

    always @(negedge clk) if (alu_opCode != 2'd0) pulse_cnt <= pulse_cnt + 1;

    function automatic logic [127:0] ref_result(input logic [63:0] a, b, input logic [1:0] op);
        logic signed [127:0] ea, eb;
        ea = $signed(a);
        eb = $signed(b);
        if (op == 2'd1) return ea + eb;
        if (op == 2'd2) return ea * eb;
        return 128'd0;
    endfunction

    task automatic send(input logic [63:0] a, b, input logic [1:0] op, input logic [3:0] tag);
        int k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin @(negedge clk); cyc++; end
        if (!rsp_valid) cyc = -1;
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tot++; if (req_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", req_ready); else n_pass++;
        n_tot++; if ({rsp_valid, busy, rsp_err, alu_opCode} !== 5'b0) $display("FAIL reset_ctl got %b want 0", {rsp_valid, busy, rsp_err, alu_opCode}); else n_pass++;
        n_tot++; if ({rsp_data, rsp_tag, alu_A, alu_B, op_count} !== '0) $display("FAIL reset_data got nonzero want 0"); else n_pass++;
        resetn = 1'b1;
        @(negedge clk);
        n_tot++; if (req_ready !== 1'b1) $display("FAIL idle_ready got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_add();
        int c;
        send(64'd5, -64'sd3, 2'd1, 4'd3);
        wait_rsp(c);
        n_tot++; if (c !== 3) $display("FAIL add_latency got %0d want 3", c); else n_pass++;
        n_tot++; if (rsp_data !== 128'd2) $display("FAIL add_data got %h want 2", rsp_data); else n_pass++;
        n_tot++; if (rsp_tag !== 4'd3 || rsp_err !== 1'b0) $display("FAIL add_tag_err got %0d/%b want 3/0", rsp_tag, rsp_err); else n_pass++;
        ack();
        exp_count++;
        n_tot++; if (op_count !== 32'(exp_count)) $display("FAIL add_count got %0d want %0d", op_count, exp_count); else n_pass++;
    endtask

    task automatic test_mul();
        int c, p0;
        p0 = pulse_cnt;
        send(-64'sd4, 64'd7, 2'd2, 4'd5);
        wait_rsp(c);
        n_tot++; if (rsp_data !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFE4) $display("FAIL mul_data got %h want ..FFE4", rsp_data); else n_pass++;
        n_tot++; if (pulse_cnt - p0 !== 1) $display("FAIL mul_pulse got %0d want 1", pulse_cnt - p0); else n_pass++;
        n_tot++; if (alu_A !== 64'hFFFF_FFFF_FFFF_FFFC || alu_B !== 64'd7) $display("FAIL mul_operands got %h/%h want fffffffffffffffc/7", alu_A, alu_B); else n_pass++;
        ack();
        exp_count++;
    endtask

    task automatic test_nop_rsv();
        int c, p0;
        p0 = pulse_cnt;
        send(64'h1234, 64'h55, 2'd0, 4'd9);
        wait_rsp(c);
        n_tot++; if (c !== 0 || rsp_data !== 128'd0) $display("FAIL nop_rsp got lat %0d data %h want 0/0", c, rsp_data); else n_pass++;
        n_tot++; if (pulse_cnt - p0 !== 0 || alu_opCode !== 2'd0) $display("FAIL nop_opcode got %0d pulses want 0", pulse_cnt - p0); else n_pass++;
        n_tot++; if (alu_A !== 64'h1234 || rsp_tag !== 4'd9) $display("FAIL nop_regs got %h/%0d want 1234/9", alu_A, rsp_tag); else n_pass++;
        ack();
        exp_count++;
        send(64'd8, 64'd9, 2'd3, 4'd4);
        wait_rsp(c);
        n_tot++; if (c !== 3 || rsp_data !== 128'd0 || rsp_err !== 1'b0) $display("FAIL rsv_rsp got lat %0d data %h err %b want 3/0/0", c, rsp_data, rsp_err); else n_pass++;
        ack();
        exp_count++;
        n_tot++; if (op_count !== 32'(exp_count)) $display("FAIL rsv_count got %0d want %0d", op_count, exp_count); else n_pass++;
    endtask

    task automatic test_backpressure();
        int c;
        logic ok;
        send(64'd3, 64'd3, 2'd2, 4'd6);
        wait_rsp(c);
        req_a = 64'd10; req_b = 64'd20; req_op = 2'd1; req_tag = 4'd7; req_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_data !== 128'd9 || rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_tag !== 4'd6) ok = 1'b0;
        end
        n_tot++; if (ok !== 1'b1) $display("FAIL bp_stable got unstable hold want data 9 tag 6 ready 0"); else n_pass++;
        ack();
        exp_count++;
        n_tot++; if (req_ready !== 1'b1 || busy !== 1'b0 || op_count !== 32'(exp_count)) $display("FAIL bp_after got ready %b count %0d want 1/%0d", req_ready, op_count, exp_count); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(c);
        n_tot++; if (c !== 3 || rsp_data !== 128'd30 || rsp_tag !== 4'd7) $display("FAIL bp_next got lat %0d data %h tag %0d want 3/30/7", c, rsp_data, rsp_tag); else n_pass++;
        ack();
        exp_count++;
    endtask

    task automatic test_timeout();
        int c;
        drop = 1'b1;
        send(64'd100, 64'd200, 2'd1, 4'd10);
        wait_rsp(c);
        n_tot++; if (c !== TIMEOUT + 1) $display("FAIL to_latency got %0d want %0d", c, TIMEOUT + 1); else n_pass++;
        n_tot++; if (rsp_err !== 1'b1 || rsp_data !== 128'd0 || rsp_tag !== 4'd10) $display("FAIL to_rsp got err %b data %h tag %0d want 1/0/10", rsp_err, rsp_data, rsp_tag); else n_pass++;
        ack();
        drop = 1'b0;
        n_tot++; if (op_count !== 32'(exp_count)) $display("FAIL to_count got %0d want %0d", op_count, exp_count); else n_pass++;
    endtask

    task automatic test_stray_completion();
        logic seen;
        seen = 1'b0;
        inject = 1'b1;
        repeat (3) begin @(negedge clk); if (rsp_valid || busy) seen = 1'b1; end
        inject = 1'b0;
        n_tot++; if (seen !== 1'b0) $display("FAIL stray_completion got rsp_valid want idle"); else n_pass++;
    endtask

    task automatic test_reset_midop();
        int c;
        logic seen;
        send(64'd7, 64'd8, 2'd1, 4'd11);
        @(negedge clk);
        n_tot++; if (busy !== 1'b1) $display("FAIL midop_busy got %b want 1", busy); else n_pass++;
        resetn = 1'b0;
        #1;
        n_tot++; if ({req_ready, rsp_valid, busy, rsp_err, alu_opCode} !== 6'b0) $display("FAIL midop_ctl got %b want 0", {req_ready, rsp_valid, busy, rsp_err, alu_opCode}); else n_pass++;
        n_tot++; if ({rsp_data, rsp_tag, alu_A, alu_B, op_count} !== '0) $display("FAIL midop_data got nonzero want 0"); else n_pass++;
        exp_count = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        n_tot++; if (seen !== 1'b0) $display("FAIL midop_spurious got rsp_valid want 0"); else n_pass++;
        send(64'd1, 64'd1, 2'd1, 4'd2);
        wait_rsp(c);
        n_tot++; if (c !== 3 || rsp_data !== 128'd2) $display("FAIL midop_next got lat %0d data %h want 3/2", c, rsp_data); else n_pass++;
        ack();
        exp_count++;
        n_tot++; if (op_count !== 32'(exp_count)) $display("FAIL midop_count got %0d want %0d", op_count, exp_count); else n_pass++;
    endtask

    task automatic test_random();
        int c, lat;
        logic [63:0] a, b;
        logic [1:0] op;
        logic [3:0] tag;
        logic err;
        for (int i = 0; i < 25; i++) begin
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 1) == 0) ? 64'($signed($urandom_range(0, 200)) - 100) : {$urandom, $urandom};
            op = 2'($urandom_range(0, 3));
            tag = 4'($urandom_range(0, 15));
            err = op != 2'd0 && $urandom_range(0, 5) == 0;
            lat = op == 2'd0 ? 0 : err ? TIMEOUT + 1 : 3;
            drop = err;
            send(a, b, op, tag);
            wait_rsp(c);
            n_tot++; if (c !== lat) $display("FAIL rnd%0d_latency got %0d want %0d", i, c, lat); else n_pass++;
            n_tot++; if (rsp_data !== (err ? 128'd0 : ref_result(a, b, op))) $display("FAIL rnd%0d_data got %h want %h", i, rsp_data, err ? 128'd0 : ref_result(a, b, op)); else n_pass++;
            n_tot++; if (rsp_tag !== tag || rsp_err !== err) $display("FAIL rnd%0d_tag_err got %0d/%b want %0d/%b", i, rsp_tag, rsp_err, tag, err); else n_pass++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ack();
            drop = 1'b0;
            if (!err) exp_count++;
            n_tot++; if (op_count !== 32'(exp_count)) $display("FAIL rnd%0d_count got %0d want %0d", i, op_count, exp_count); else n_pass++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_nop_rsv();
        test_backpressure();
        test_timeout();
        test_stray_completion();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
